universal_shift_engine: RTL

//  Parametrised successor to the 8-bit universal shift register in user_proj_example.

---
 rtl/universal_shift_engine_pkg.sv | 45 ++++
 rtl/universal_shift_engine_if.sv | 27 ++
 rtl/universal_shift_engine_shift_unit.sv | 50 +++++
 rtl/universal_shift_engine.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/universal_shift_engine_pkg.sv
// Shared types for the universal shift engine: command modes, FSM states and
// the reference 1-bit step used by the iterative datapath.
package usr_pkg;

  localparam int USR_MAX_W = 64;

  typedef enum logic [2:0] {
    USR_HOLD  = 3'b000,
    USR_LOAD  = 3'b001,
    USR_SHR   = 3'b010,
    USR_SHL   = 3'b011,
    USR_ROR   = 3'b100,
    USR_ROL   = 3'b101,
    USR_ASR   = 3'b110,
    USR_CLEAR = 3'b111
  } usr_mode_e;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } usr_state_e;

  // Operates on a zero-extended value of width w; bits above w are masked off.
  function automatic logic [USR_MAX_W-1:0] usr_step(input logic [USR_MAX_W-1:0] r,
                                                    input usr_mode_e mode,
                                                    input logic fill_l,
                                                    input logic fill_r,
                                                    input int unsigned w);
    logic [USR_MAX_W-1:0] res;
    logic [USR_MAX_W-1:0] mask;
    logic [USR_MAX_W-1:0] top;
    mask = {USR_MAX_W{1'b1}} >> (USR_MAX_W - w);
    top  = USR_MAX_W'(1) << (w - 1);
    case (mode)
      USR_SHR: res = (r >> 1) | (fill_l ? top : '0);
      USR_SHL: res = (r << 1) | USR_MAX_W'(fill_r);
      USR_ROR: res = (r >> 1) | (r[0] ? top : '0);
      USR_ROL: res = (r << 1) | USR_MAX_W'((r & top) != '0);
      USR_ASR: res = (r >> 1) | (r & top);
      default: res = r;
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/universal_shift_engine_if.sv
// Command/response bundle of the universal shift engine; the engine is the
// slave, whoever issues commands is the master.
interface universal_shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_mode;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] data_in;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] reg_out;
  logic             out_valid;
  logic             busy;

  modport master (
    output cmd_valid, cmd_mode, cmd_amt, data_in, ser_in_l, ser_in_r,
    input  cmd_ready, reg_out, out_valid, busy
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_amt, data_in, ser_in_l, ser_in_r,
    output cmd_ready, reg_out, out_valid, busy
  );
endinterface

// File: rtl/universal_shift_engine_shift_unit.sv
// Combinational shift datapath: one 1-bit step by default, or a full
// log2 barrel shift over cmd_amt when USR_BARREL_EN is defined.
module usr_shift_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic [WIDTH-1:0] reg_i,
  input  usr_mode_e        mode_i,
`ifdef USR_BARREL_EN
  input  logic [AMT_W-1:0] amt_i,
`endif
  input  logic             fill_l_i,
  input  logic             fill_r_i,
  output logic [WIDTH-1:0] res_o
);

`ifdef USR_BARREL_EN
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  int               k;

  // Stage b shifts by 2**b; fills beyond WIDTH saturate to all-fill / all-MSB.
  always_comb begin
    cur = reg_i;
    nxt = reg_i;
    k   = 0;
    for (int b = 0; b < AMT_W; b++) begin
      k   = 1 << b;
      nxt = cur;
      for (int i = 0; i < WIDTH; i++) begin
        case (mode_i)
          USR_SHR: nxt[i] = (i + k < WIDTH) ? cur[(i + k) % WIDTH] : fill_l_i;
          USR_SHL: nxt[i] = (i >= k) ? cur[(i - (k % WIDTH) + WIDTH) % WIDTH] : fill_r_i;
          USR_ROR: nxt[i] = cur[(i + k) % WIDTH];
          USR_ROL: nxt[i] = cur[(i - (k % WIDTH) + WIDTH) % WIDTH];
          USR_ASR: nxt[i] = (i + k < WIDTH) ? cur[(i + k) % WIDTH] : cur[WIDTH-1];
          default: nxt[i] = cur[i];
        endcase
      end
      if (amt_i[b]) cur = nxt;
    end
    res_o = cur;
  end
`else
  assign res_o = WIDTH'(usr_step(USR_MAX_W'(reg_i), mode_i, fill_l_i, fill_r_i, WIDTH));
`endif

endmodule

// File: rtl/universal_shift_engine.sv
// Universal shift/rotate/load engine behind a valid/ready handshake.
// Iterative (1 bit per clock) by default; define USR_BARREL_EN for single-cycle shifts.
module universal_shift_engine
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  universal_shift_engine_if.slave bus
);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic [WIDTH-1:0] shift_res;
  logic             valid_q, valid_d;
  logic             ready;
  logic             accept;
  usr_mode_e        cmd_mode;

  assign cmd_mode = usr_mode_e'(bus.cmd_mode);
  assign accept   = bus.cmd_valid && ready;

`ifdef USR_BARREL_EN
  usr_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_shift (
    .reg_i    (reg_q),
    .mode_i   (cmd_mode),
    .amt_i    (bus.cmd_amt),
    .fill_l_i (bus.ser_in_l),
    .fill_r_i (bus.ser_in_r),
    .res_o    (shift_res)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      reg_q   <= reg_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    reg_d   = reg_q;
    valid_d = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      case (cmd_mode)
        USR_HOLD:  reg_d = reg_q;
        USR_LOAD:  reg_d = bus.data_in;
        USR_CLEAR: reg_d = '0;
        default:   reg_d = shift_res;
      endcase
    end
  end

  always_comb begin
    ready         = reset_n;
    bus.cmd_ready = ready;
    bus.busy      = 1'b0;
    bus.reg_out   = reg_q;
    bus.out_valid = valid_q;
  end
`else
  usr_state_e       state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  usr_mode_e        mode_q, mode_d;
  logic             fill_l_q, fill_l_d;
  logic             fill_r_q, fill_r_d;
  usr_mode_e        unit_mode;
  logic             unit_fill_l;
  logic             unit_fill_r;

  // The acceptance edge already performs step 1, so the unit sees the live
  // command in IDLE and the latched one while shifting.
  assign unit_mode   = (state_q == S_SHIFT) ? mode_q   : cmd_mode;
  assign unit_fill_l = (state_q == S_SHIFT) ? fill_l_q : bus.ser_in_l;
  assign unit_fill_r = (state_q == S_SHIFT) ? fill_r_q : bus.ser_in_r;

  usr_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_shift (
    .reg_i    (reg_q),
    .mode_i   (unit_mode),
    .fill_l_i (unit_fill_l),
    .fill_r_i (unit_fill_r),
    .res_o    (shift_res)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reg_q    <= '0;
      mode_q   <= USR_HOLD;
      fill_l_q <= 1'b0;
      fill_r_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reg_q    <= reg_d;
      mode_q   <= mode_d;
      fill_l_q <= fill_l_d;
      fill_r_q <= fill_r_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reg_d    = reg_q;
    mode_d   = mode_q;
    fill_l_d = fill_l_q;
    fill_r_d = fill_r_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d   = cmd_mode;
          fill_l_d = bus.ser_in_l;
          fill_r_d = bus.ser_in_r;
          case (cmd_mode)
            USR_HOLD:  valid_d = 1'b1;
            USR_LOAD:  begin reg_d = bus.data_in; valid_d = 1'b1; end
            USR_CLEAR: begin reg_d = '0;          valid_d = 1'b1; end
            default: begin
              if (bus.cmd_amt == '0) begin
                valid_d = 1'b1;
              end else begin
                reg_d = shift_res;
                if (bus.cmd_amt > AMT_W'(1)) begin
                  cnt_d   = bus.cmd_amt - AMT_W'(1);
                  state_d = S_SHIFT;
                end else begin
                  valid_d = 1'b1;
                end
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        reg_d = shift_res;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready         = reset_n && (state_q == S_IDLE);
    bus.cmd_ready = ready;
    bus.busy      = (state_q == S_SHIFT);
    bus.reg_out   = reg_q;
    bus.out_valid = valid_q;
  end
`endif

endmodule
